// File: rtl/uart_rx16.sv
// uart_rx16: 8N1 UART receiver, 16x oversampled with 3-sample majority vote, valid/ready holding register
module uart_rx16 #(
   parameter int DATA_BITS = 8
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 baud16,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int IW = $clog2(DATA_BITS);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_nx;
   logic s1, rxd_s, b_q, tick;
   logic [3:0] os_cnt, os_nx, os_inc;
   logic [IW-1:0] bit_idx, idx_nx;
   logic [DATA_BITS-1:0] shreg, sh_nx;
   logic [1:0] vote, vote_nx;
   logic bit_dec, last_bit, stop_ok, stop_bad, load;
   assign tick     = baud16 & ~b_q;
   assign os_inc   = os_cnt + 4'd1;
   assign bit_dec  = (vote[1] & vote[0]) | (vote[1] & rxd_s) | (vote[0] & rxd_s);
   assign last_bit = bit_idx == IW'(DATA_BITS - 1);
   assign load     = stop_ok & (~rx_valid | rx_ready);
   // two-flop rxd synchronizer and baud16 rising-edge detector
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) {s1, rxd_s, b_q} <= 3'b110;
      else {s1, rxd_s, b_q} <= {rxd, s1, baud16};
   // frame state registers and output holding register
   always_ff @(posedge sys_clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         os_cnt    <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         vote      <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nx;
         os_cnt    <= os_nx;
         bit_idx   <= idx_nx;
         shreg     <= sh_nx;
         vote      <= vote_nx;
         rx_data   <= load ? shreg : rx_data;
         rx_valid  <= load | (rx_valid & ~rx_ready);
         frame_err <= stop_bad;
         overrun   <= stop_ok & ~load;
      end
   // per-tick oversampling, vote and bit decision; the third vote sample is the live rxd_s
   always_comb begin
      state_nx = state;
      os_nx    = os_cnt;
      idx_nx   = bit_idx;
      sh_nx    = shreg;
      vote_nx  = vote;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      if (tick && state == IDLE) begin
         state_nx = rxd_s ? IDLE : START;
         os_nx    = 4'd0;
      end else if (tick) begin
         os_nx = os_inc;
         if (os_inc == 4'd7 || os_inc == 4'd8) vote_nx = {vote[0], rxd_s};
         if (os_inc == 4'd9) begin
            if (state == START) begin
               state_nx = bit_dec ? IDLE : DATA;
               os_nx    = bit_dec ? 4'd0 : os_inc;
               idx_nx   = '0;
            end else if (state == DATA) begin
               sh_nx    = {bit_dec, shreg[DATA_BITS-1:1]};
               state_nx = last_bit ? STOP : DATA;
               idx_nx   = last_bit ? '0 : bit_idx + 1'b1;
            end else begin
               state_nx = IDLE;
               os_nx    = 4'd0;
               stop_ok  = bit_dec;
               stop_bad = ~bit_dec;
            end
         end
      end
   end
endmodule

// File: tb/tb_uart_rx16.sv
// tb_uart_rx16: randomized scoreboard bench for uart_rx16 at 115200 baud on a 200 MHz clock
`timescale 1ns/1ps
module tb_uart_rx16;
   localparam int BIT = 1736;
   logic sys_clk = 0, rst_n = 0, baud16 = 0, rxd = 1, rx_ready = 1;
   logic [7:0] rx_data, e, b;
   logic rx_valid, frame_err, overrun, stop;
   int checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0;
   bit held = 0;
   logic [7:0] exp_q[$];

   uart_rx16 #(.DATA_BITS(8)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .baud16(baud16), .rxd(rxd),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_err(frame_err), .overrun(overrun)
   );

   always #2.5 sys_clk = ~sys_clk;

   // 16x baud square wave, rising edges alternately 108 and 109 clocks apart
   initial forever begin
      repeat (54) @(posedge sys_clk); #1 baud16 = 1;
      repeat (54) @(posedge sys_clk); #1 baud16 = 0;
      repeat (54) @(posedge sys_clk); #1 baud16 = 1;
      repeat (55) @(posedge sys_clk); #1 baud16 = 0;
   end

   // monitor: pops the scoreboard on every transfer and tallies flag pulses
   always @(negedge sys_clk) if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) begin
         checks++; errors++;
         $display("FAIL flags_together: frame_err=1 overrun=1, required not both");
      end
      if (rx_valid && rx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_byte: got %02h, required no transfer", rx_data);
         end else begin
            e = exp_q.pop_front();
            if (rx_data !== e) begin
               errors++;
               $display("FAIL rx_data: got %02h, required %02h", rx_data, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic idle(input int bits);
      rxd = 1;
      wait_cycles(BIT * bits);
   endtask

   task automatic send_bit(input logic v, input bit g);
      rxd = v;
      if (g) begin
         wait_cycles(814); rxd = 0; wait_cycles(108); rxd = v; wait_cycles(814);
      end else wait_cycles(BIT);
   endtask

   // reference model: what the receiver must do with one complete frame given the current rx_ready
   task automatic model(input logic [7:0] d, input logic s);
      if (!s) exp_fe++;
      else if (held && !rx_ready) exp_ov++;
      else begin
         exp_q.push_back(d);
         held = !rx_ready;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic s, input bit g);
      model(d, s);
      send_bit(0, 0);
      for (int i = 0; i < 8; i++) send_bit(d[i], g);
      send_bit(s, 0);
      rxd = 1;
   endtask

   task automatic check_flags(input string name);
      check({name, "_frame_err_count"}, fe_cnt, exp_fe);
      check({name, "_overrun_count"}, ov_cnt, exp_ov);
   endtask

   initial begin
      wait_cycles(10);
      check("reset_rx_valid", rx_valid, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_overrun", overrun, 0);
      rst_n = 1;
      idle(2);
      send_frame(8'h55, 1, 0);
      send_frame(8'hA3, 1, 0);
      idle(2);
      check("b2b_drained", exp_q.size(), 0);
      check_flags("b2b");
      rxd = 0;
      wait_cycles(326);
      idle(2);
      check("false_start_valid", rx_valid, 0);
      check_flags("false_start");
      send_frame(8'h3C, 0, 0);
      idle(2);
      check("frame_err_valid", rx_valid, 0);
      check_flags("frame_err");
      rx_ready = 0;
      send_frame(8'h11, 1, 0);
      send_frame(8'h22, 1, 0);
      idle(2);
      check("overrun_valid", rx_valid, 1);
      check("overrun_data", rx_data, 8'h11);
      check_flags("overrun");
      rx_ready = 1;
      held = 0;
      wait_cycles(1);
      rx_ready = 0;
      check("drain_valid_clear", rx_valid, 0);
      rx_ready = 1;
      check("drain_popped", exp_q.size(), 0);
      send_bit(0, 0);
      for (int i = 0; i < 4; i++) send_bit(1, 0);
      rxd = 1;
      wait_cycles(868);
      rst_n = 0;
      wait_cycles(5);
      check("midreset_rx_valid", rx_valid, 0);
      check("midreset_rx_data", rx_data, 0);
      check("midreset_frame_err", frame_err, 0);
      check("midreset_overrun", overrun, 0);
      rst_n = 1;
      idle(5);
      check_flags("midreset");
      send_frame(8'h81, 1, 0);
      idle(2);
      check("after_reset_drained", exp_q.size(), 0);
      send_frame(8'hFF, 1, 1);
      idle(2);
      check("glitch_drained", exp_q.size(), 0);
      check_flags("glitch");
      for (int n = 0; n < 12; n++) begin
         b = 8'($urandom_range(0, 255));
         stop = ($urandom_range(0, 4) != 0);
         send_frame(b, stop, bit'($urandom_range(0, 1)));
         idle(stop ? int'($urandom_range(0, 1)) : 1);
      end
      for (int n = 0; n < 5000 && exp_q.size() != 0; n++) wait_cycles(1);
      idle(1);
      check("random_drained", exp_q.size(), 0);
      check_flags("random");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
